// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, bus widths and the fill FSM state encoding.
package fb_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_ADDR_W = 19;
  localparam int FB_PIX_W  = 8;

  typedef logic [1:0] fill_state_t;

  localparam fill_state_t FILL_IDLE = 2'd0;
  localparam fill_state_t FILL_LOAD = 2'd1;
  localparam fill_state_t FILL_RUN  = 2'd2;
  localparam fill_state_t FILL_DONE = 2'd3;

endpackage

// File: rtl/fb_fill_engine.sv
// Rectangle-fill engine: clips the command to the screen and walks its pixels row-major.
// First pixel request two cycles after the command handshake; advances only on grant.
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [9:0]           cmd_x,
  input  logic [9:0]           cmd_y,
  input  logic [9:0]           cmd_w,
  input  logic [9:0]           cmd_h,
  input  logic [FB_PIX_W-1:0]  cmd_color,
  output logic                 req,
  output logic [FB_ADDR_W-1:0] addr,
  output logic [FB_PIX_W-1:0]  color,
  output logic                 last,
  input  logic                 grant,
  output logic                 busy,
  output logic                 done
);

  localparam logic [10:0]          W11      = 11'(WIDTH);
  localparam logic [10:0]          H11      = 11'(HEIGHT);
  localparam logic [FB_ADDR_W-1:0] ROW_STEP = FB_ADDR_W'(WIDTH);

  fill_state_t          state;
  fill_state_t          state_nxt;
  logic [9:0]           x_q, y_q, w_q, h_q;
  logic [10:0]          x0, xe, ye, cx, cy;
  logic [FB_ADDR_W-1:0] row_base;
  logic [10:0]          x_sum, y_sum, xe_c, ye_c;
  logic                 empty_c;
  logic                 row_end;

  // 11-bit sums cannot overflow, so the min() against the screen edge is exact.
  assign x_sum   = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum   = {1'b0, y_q} + {1'b0, h_q};
  assign xe_c    = (x_sum > W11) ? W11 : x_sum;
  assign ye_c    = (y_sum > H11) ? H11 : y_sum;
  assign empty_c = (w_q == 10'd0) || (h_q == 10'd0) ||
                   ({1'b0, x_q} >= W11) || ({1'b0, y_q} >= H11);

  assign row_end   = (cx + 11'd1 == xe);
  assign last      = row_end && (cy + 11'd1 == ye);
  assign addr      = row_base + FB_ADDR_W'(cx);
  assign req       = (state == FILL_RUN);
  assign cmd_ready = (state == FILL_IDLE);
  assign busy      = (state != FILL_IDLE);
  assign done      = (state == FILL_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      FILL_IDLE: if (cmd_valid) state_nxt = FILL_LOAD;
      FILL_LOAD: state_nxt = empty_c ? FILL_DONE : FILL_RUN;
      FILL_RUN:  if (grant && last) state_nxt = FILL_DONE;
      default:   state_nxt = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FILL_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color    <= '0;
      x0       <= '0;
      xe       <= '0;
      ye       <= '0;
      cx       <= '0;
      cy       <= '0;
      row_base <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_valid && cmd_ready) begin
        x_q   <= cmd_x;
        y_q   <= cmd_y;
        w_q   <= cmd_w;
        h_q   <= cmd_h;
        color <= cmd_color;
      end
      if (state == FILL_LOAD) begin
        x0       <= {1'b0, x_q};
        cx       <= {1'b0, x_q};
        cy       <= {1'b0, y_q};
        xe       <= xe_c;
        ye       <= ye_c;
        row_base <= FB_ADDR_W'(y_q) * ROW_STEP;
      end else if (state == FILL_RUN && grant) begin
        if (row_end) begin
          cx       <= x0;
          cy       <= cy + 11'd1;
          row_base <= row_base + ROW_STEP;
        end else begin
          cx <= cx + 11'd1;
        end
      end
    end
  end

endmodule

// File: rtl/fb_write_ctrl.sv
// Shares the framebuffer write port between CPU stores and the fill engine, CPU first.
// One-cycle grant-to-write latency; cpu_ready drops one slot after STARVE_MAX CPU wins during a fill.
module fb_write_ctrl
  import fb_pkg::*;
#(
  parameter int WIDTH      = FB_WIDTH,
  parameter int HEIGHT     = FB_HEIGHT,
  parameter int STARVE_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_valid,
  output logic                 cpu_ready,
  input  logic [FB_ADDR_W-1:0] cpu_addr,
  input  logic [FB_PIX_W-1:0]  cpu_data,
  output logic                 cpu_drop,
  input  logic                 fill_valid,
  output logic                 fill_ready,
  input  logic [9:0]           fill_x,
  input  logic [9:0]           fill_y,
  input  logic [9:0]           fill_w,
  input  logic [9:0]           fill_h,
  input  logic [FB_PIX_W-1:0]  fill_color,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic [FB_ADDR_W-1:0] fb_address,
  output logic [FB_PIX_W-1:0]  fb_data,
  output logic                 fb_w_en
);

  localparam int                   STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0]  STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [FB_ADDR_W-1:0] PIX_COUNT  = FB_ADDR_W'(WIDTH * HEIGHT);

  logic                 fill_req;
  logic                 fill_last;
  logic                 fill_grant;
  logic [FB_ADDR_W-1:0] fill_addr;
  logic [FB_PIX_W-1:0]  fill_pix;
  logic                 cpu_grant;
  logic                 cpu_in_range;
  logic                 starved;
  logic [STARVE_W-1:0]  starve;

  fb_fill_engine #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_fill (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (fill_valid),
    .cmd_ready (fill_ready),
    .cmd_x     (fill_x),
    .cmd_y     (fill_y),
    .cmd_w     (fill_w),
    .cmd_h     (fill_h),
    .cmd_color (fill_color),
    .req       (fill_req),
    .addr      (fill_addr),
    .color     (fill_pix),
    .last      (fill_last),
    .grant     (fill_grant),
    .busy      (fill_busy),
    .done      (fill_done)
  );

  assign starved      = fill_req && (starve == STARVE_LIM);
  assign cpu_ready    = !starved;
  assign cpu_grant    = cpu_valid && cpu_ready;
  assign fill_grant   = fill_req && !cpu_grant;
  assign cpu_in_range = (cpu_addr < PIX_COUNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve <= '0;
    end else if (!fill_req || fill_grant) begin
      starve <= '0;
    end else if (cpu_grant && starve != STARVE_LIM) begin
      starve <= starve + 1'b1;
    end
  end

  // Out-of-range stores still consume their grant slot but never reach the framebuffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_w_en    <= 1'b0;
      fb_address <= '0;
      fb_data    <= '0;
      cpu_drop   <= 1'b0;
    end else begin
      fb_w_en  <= 1'b0;
      cpu_drop <= 1'b0;
      if (cpu_grant) begin
        if (cpu_in_range) begin
          fb_w_en    <= 1'b1;
          fb_address <= cpu_addr;
          fb_data    <= cpu_data;
        end else begin
          cpu_drop <= 1'b1;
        end
      end else if (fill_grant) begin
        fb_w_en    <= 1'b1;
        fb_address <= fill_addr;
        fb_data    <= fill_pix;
      end
    end
  end

  a_last_then_done: assert property (@(posedge clk) disable iff (!rst)
    (fill_grant && fill_last) |=> fill_done);

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Randomized bench for fb_write_ctrl against a queue-based model of the write-port rules.
module tb_fb_write_ctrl;

  localparam int W    = 640;
  localparam int H    = 480;
  localparam int SMAX = 15;
  localparam int NPIX = W * H;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic [18:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        cpu_drop;
  logic        fill_valid = 1'b0;
  logic        fill_ready;
  logic [9:0]  fill_x = '0, fill_y = '0, fill_w = '0, fill_h = '0;
  logic [7:0]  fill_color = '0;
  logic        fill_busy;
  logic        fill_done;
  logic [18:0] fb_address;
  logic [7:0]  fb_data;
  logic        fb_w_en;

  fb_write_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_drop(cpu_drop),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_x(fill_x), .fill_y(fill_y), .fill_w(fill_w), .fill_h(fill_h),
    .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
    .fb_address(fb_address), .fb_data(fb_data), .fb_w_en(fb_w_en)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // Reference model: pending fill pixels as a queue of linear addresses.
  int          m_phase = P_IDLE;
  int          m_starve = 0;
  int unsigned m_list[$];
  int unsigned m_color = 0;
  logic        e_wen, e_drop;
  int unsigned e_addr, e_data;

  int          cyc = 0;
  int          cpu_mode = 0;
  int          nstall = 0;
  int unsigned log_addr[$];
  int unsigned log_data[$];
  int          log_cyc[$];

  function automatic void model_reset();
    m_phase  = P_IDLE;
    m_starve = 0;
    m_list.delete();
  endfunction

  function automatic void model_step();
    bit cpu_win;
    e_wen  = 1'b0;
    e_drop = 1'b0;
    if (!rst) begin
      model_reset();
      return;
    end
    cpu_win = cpu_valid && !(m_phase == P_RUN && m_starve == SMAX);
    if (cpu_win) begin
      if (int'(cpu_addr) < NPIX) begin
        e_wen = 1'b1; e_addr = cpu_addr; e_data = cpu_data;
      end else begin
        e_drop = 1'b1;
      end
    end
    case (m_phase)
      P_IDLE: begin
        m_starve = 0;
        if (fill_valid) begin
          int xe, ye;
          xe = (int'(fill_x) + int'(fill_w) > W) ? W : int'(fill_x) + int'(fill_w);
          ye = (int'(fill_y) + int'(fill_h) > H) ? H : int'(fill_y) + int'(fill_h);
          m_list.delete();
          for (int yy = int'(fill_y); yy < ye; yy++)
            for (int xx = int'(fill_x); xx < xe; xx++)
              m_list.push_back(yy * W + xx);
          m_color = fill_color;
          m_phase = P_LOAD;
        end
      end
      P_LOAD: begin
        m_starve = 0;
        m_phase = (m_list.size() == 0) ? P_DONE : P_RUN;
      end
      P_RUN: begin
        if (cpu_win) begin
          if (m_starve < SMAX) m_starve++;
        end else begin
          e_wen = 1'b1; e_addr = m_list.pop_front(); e_data = m_color;
          m_starve = 0;
          if (m_list.size() == 0) m_phase = P_DONE;
        end
      end
      default: begin
        m_starve = 0;
        m_phase = P_IDLE;
      end
    endcase
  endfunction

  task automatic tick();
    if (cpu_mode == 1) begin
      cpu_valid = 1'b1;
      cpu_addr  = 19'($urandom_range(0, NPIX - 1));
      cpu_data  = 8'($urandom);
    end else if (cpu_mode == 2) begin
      cpu_valid = ($urandom_range(0, 2) == 0);
      cpu_addr  = ($urandom_range(0, 7) == 0) ? 19'(NPIX + $urandom_range(0, 1000))
                                              : 19'($urandom_range(0, NPIX - 1));
      cpu_data  = 8'($urandom);
    end
    expect_eq("cpu_ready", 32'(cpu_ready), (m_phase == P_RUN && m_starve == SMAX) ? 0 : 1);
    expect_eq("fill_ready", 32'(fill_ready), (m_phase == P_IDLE) ? 1 : 0);
    if (cpu_valid && !cpu_ready) nstall++;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    expect_eq("fb_w_en", 32'(fb_w_en), 32'(e_wen));
    expect_eq("cpu_drop", 32'(cpu_drop), 32'(e_drop));
    expect_eq("fill_busy", 32'(fill_busy), (m_phase != P_IDLE) ? 1 : 0);
    expect_eq("fill_done", 32'(fill_done), (m_phase == P_DONE) ? 1 : 0);
    if (e_wen) begin
      expect_eq("fb_address", 32'(fb_address), e_addr);
      expect_eq("fb_data", 32'(fb_data), e_data);
    end
    if (fb_w_en) begin
      log_addr.push_back(fb_address);
      log_data.push_back(fb_data);
      log_cyc.push_back(cyc);
    end
  endtask

  task automatic run_fill(input int x, input int y, input int w, input int h, input int c,
                          output int t_hs, output int t_done);
    fill_x = 10'(x); fill_y = 10'(y); fill_w = 10'(w); fill_h = 10'(h);
    fill_color = 8'(c);
    fill_valid = 1'b1;
    t_hs = -1;
    t_done = -1;
    for (int i = 0; i < 50 && t_hs < 0; i++) begin
      if (fill_ready) t_hs = cyc;
      tick();
    end
    fill_valid = 1'b0;
    if (t_hs < 0) expect_eq("fill_hs_timeout", 0, 1);
    for (int i = 0; i < 3000 && t_done < 0; i++) begin
      if (fill_done) t_done = cyc;
      else tick();
    end
    if (t_done < 0) expect_eq("fill_done_timeout", 0, 1);
    else tick();
  endtask

  function automatic void clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endfunction

  initial begin
    int t_hs, t_done;
    int unsigned basic_addr[6];
    basic_addr = '{642, 643, 644, 1282, 1283, 1284};

    // Reset and idle
    #2 rst = 1'b0;
    #1;
    expect_eq("rst_w_en_async", 32'(fb_w_en), 0);
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b1;
    tick();
    expect_eq("rst_fb_address", 32'(fb_address), 0);
    expect_eq("rst_fb_data", 32'(fb_data), 0);
    expect_eq("idle_fill_ready", 32'(fill_ready), 1);
    expect_eq("idle_cpu_ready", 32'(cpu_ready), 1);

    // Basic fill
    clear_log();
    run_fill(2, 1, 3, 2, 8'hA5, t_hs, t_done);
    expect_eq("basic_nwrites", log_addr.size(), 6);
    for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
      expect_eq("basic_addr", log_addr[i], basic_addr[i]);
      expect_eq("basic_data", log_data[i], 32'hA5);
      expect_eq("basic_cycle", log_cyc[i], t_hs + 3 + i);
    end
    expect_eq("basic_done_cycle", t_done, t_hs + 8);

    // Clipping at the bottom-right corner
    clear_log();
    run_fill(638, 479, 5, 5, 8'h11, t_hs, t_done);
    expect_eq("clip_nwrites", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      expect_eq("clip_addr0", log_addr[0], 307198);
      expect_eq("clip_addr1", log_addr[1], 307199);
    end

    // Empty fill
    clear_log();
    run_fill(10, 10, 0, 5, 8'h22, t_hs, t_done);
    expect_eq("empty_done_cycle", t_done, t_hs + 2);
    expect_eq("empty_nwrites", log_addr.size(), 0);

    // CPU contention during a 4-pixel fill
    nstall = 0;
    cpu_mode = 1;
    run_fill(100, 200, 4, 1, 8'h5A, t_hs, t_done);
    cpu_mode = 0;
    cpu_valid = 1'b0;
    expect_eq("contend_stalls", nstall, 4);
    expect_eq("contend_done_cycle", t_done, t_hs + 66);
    tick();

    // Out-of-range store then a normal one
    cpu_valid = 1'b1; cpu_addr = 19'd307200; cpu_data = 8'h11;
    tick();
    expect_eq("oor_drop", 32'(cpu_drop), 1);
    expect_eq("oor_w_en", 32'(fb_w_en), 0);
    cpu_addr = 19'd0; cpu_data = 8'h3C;
    tick();
    expect_eq("store0_w_en", 32'(fb_w_en), 1);
    expect_eq("store0_addr", 32'(fb_address), 0);
    expect_eq("store0_data", 32'(fb_data), 32'h3C);
    expect_eq("store0_drop", 32'(cpu_drop), 0);
    cpu_valid = 1'b0;
    tick();

    // Reset mid-fill
    fill_x = 10'd0; fill_y = 10'd10; fill_w = 10'd100; fill_h = 10'd1; fill_color = 8'h77;
    fill_valid = 1'b1;
    tick();
    fill_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    expect_eq("prereset_w_en", 32'(fb_w_en), 1);
    rst = 1'b0;
    model_reset();
    #1;
    expect_eq("midrst_w_en", 32'(fb_w_en), 0);
    expect_eq("midrst_busy", 32'(fill_busy), 0);
    expect_eq("midrst_done", 32'(fill_done), 0);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    clear_log();
    run_fill(5, 5, 2, 2, 8'h99, t_hs, t_done);
    expect_eq("postrst_nwrites", log_addr.size(), 4);

    // Random mixed traffic
    cpu_mode = 2;
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 4);
      for (int i = 0; i < gap; i++) tick();
      run_fill($urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 12),
               $urandom_range(0, 6), $urandom_range(0, 255), t_hs, t_done);
    end
    cpu_mode = 0;
    cpu_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
